// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio level meter: I2S receive states,
// level word field positions and the saturating magnitude used by the peak tracker.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } i2s_state_e;

  localparam int LVL_PEAK_LSB = 0;
  localparam int LVL_PEAK_W   = 16;
  localparam int LVL_CNT_LSB  = 16;
  localparam int LVL_CNT_W    = 8;
  localparam int LVL_CLIP_BIT = 30;
  localparam int LVL_FERR_BIT = 31;

  // |s| for a two's complement word; -32768 folds to 32767 so the result fits 15 bits
  function automatic logic [15:0] abs_sat16(input logic [15:0] s);
    logic [15:0] r;
    if (s == 16'h8000) begin
      r = 16'h7FFF;
    end else if (s[15]) begin
      r = 16'h0000 - s;
    end else begin
      r = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous codec pin, followed by a registered
// copy so rising/falling edges are seen as a one-cycle compare of stable flops.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // synchroniser chain plus one-cycle history for edge compare
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/audio_level_meter.sv
// I2S ADC front end: captures left-channel words from the codec stream, tracks a
// decaying peak and publishes a 32-bit level word for software polling.
module audio_level_meter
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int WINDOW_LOG2 = 10,
  parameter int DECAY_SHIFT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  adc_bclk,
  input  logic                  adc_lrck,
  input  logic                  adc_dat,
  input  logic                  clear_flags,
  output logic [DATA_WIDTH-1:0] sample_left,
  output logic                  sample_valid,
  output logic [31:0]           level_export
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic bclk_rise_s;
  logic bclk_fall_unused_s;
  logic lrck_rise_s;
  logic lrck_fall_s;
  logic dat_meta_q;
  logic dat_sync_q;

  i2s_state_e            state_q, state_d;
  logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  capture_s;
  logic                  abort_s;
  logic [DATA_WIDTH-1:0] sample_left_q;
  logic                  sample_valid_q;

  logic [15:0]            peak_q, peak_d;
  logic [15:0]            abs_s;
  logic [15:0]            decayed_s;
  logic [WINDOW_LOG2-1:0] win_q;
  logic                   wrap_s;
  logic [15:0]            lvl_peak_q;
  logic [7:0]             lvl_cnt_q;
  logic                   clip_set_s;
  logic                   clip_q;
  logic                   ferr_q;

  sync_edge u_bclk_sync (
    .clk    (clk),
    .reset  (reset),
    .async_i(adc_bclk),
    .rise_o (bclk_rise_s),
    .fall_o (bclk_fall_unused_s)
  );

  sync_edge u_lrck_sync (
    .clk    (clk),
    .reset  (reset),
    .async_i(adc_lrck),
    .rise_o (lrck_rise_s),
    .fall_o (lrck_fall_s)
  );

  // data only needs to line up with the synchronised BCLK, so no edge stage
  always_ff @(posedge clk) begin
    if (reset) begin
      dat_meta_q <= 1'b0;
      dat_sync_q <= 1'b0;
    end else begin
      dat_meta_q <= adc_dat;
      dat_sync_q <= dat_meta_q;
    end
  end

  // I2S receive next-state; an LRCK edge always outranks a coincident BCLK rise
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    capture_s = 1'b0;
    abort_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (lrck_fall_s) begin
          state_d  = bclk_rise_s ? SHIFT : SKIP;
          bitcnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SKIP, SHIFT: begin
        if (lrck_fall_s || lrck_rise_s) begin
          abort_s  = 1'b1;
          bitcnt_d = '0;
          if (lrck_fall_s) begin
            state_d = bclk_rise_s ? SHIFT : SKIP;
          end else begin
            state_d = IDLE;
          end
        end else if (bclk_rise_s) begin
          if (state_q == SKIP) begin
            state_d  = SHIFT;
            bitcnt_d = '0;
          end else begin
            shift_d = {shift_q[DATA_WIDTH-2:0], dat_sync_q};
            if (bitcnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              capture_s = 1'b1;
              state_d   = DONE;
            end else begin
              bitcnt_d = bitcnt_q + CNT_W'(1);
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      DONE: begin
        if (lrck_rise_s) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // receiver state, shift register and the published sample
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      bitcnt_q       <= '0;
      shift_q        <= '0;
      sample_left_q  <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bitcnt_q       <= bitcnt_d;
      shift_q        <= shift_d;
      sample_valid_q <= capture_s;
      if (capture_s) begin
        sample_left_q <= shift_d;
      end
    end
  end

  // the decay subtract cannot underflow because peak>>DECAY_SHIFT <= peak
  always_comb begin
    abs_s      = abs_sat16(sample_left_q);
    decayed_s  = peak_q - (peak_q >> DECAY_SHIFT);
    peak_d     = peak_q;
    clip_set_s = 1'b0;
    wrap_s     = 1'b0;
    if (sample_valid_q) begin
      peak_d     = (abs_s > decayed_s) ? abs_s : decayed_s;
      clip_set_s = (sample_left_q == 16'h7FFF) || (sample_left_q == 16'h8000);
      wrap_s     = (win_q == {WINDOW_LOG2{1'b1}});
    end else begin
      peak_d = peak_q;
    end
  end

  // peak tracker, window bookkeeping and sticky flags (set outranks clear)
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q     <= '0;
      win_q      <= '0;
      lvl_peak_q <= '0;
      lvl_cnt_q  <= '0;
      clip_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      peak_q <= peak_d;
      if (sample_valid_q) begin
        win_q <= win_q + WINDOW_LOG2'(1);
      end
      if (wrap_s) begin
        lvl_peak_q <= peak_d;
        lvl_cnt_q  <= lvl_cnt_q + 8'd1;
      end
      if (clip_set_s) begin
        clip_q <= 1'b1;
      end else if (clear_flags) begin
        clip_q <= 1'b0;
      end
      if (abort_s) begin
        ferr_q <= 1'b1;
      end else if (clear_flags) begin
        ferr_q <= 1'b0;
      end
    end
  end

  // level word assembled from registered fields only
  always_comb begin
    level_export                                 = 32'h0000_0000;
    level_export[LVL_PEAK_LSB +: LVL_PEAK_W]     = lvl_peak_q;
    level_export[LVL_CNT_LSB +: LVL_CNT_W]       = lvl_cnt_q;
    level_export[LVL_CLIP_BIT]                   = clip_q;
    level_export[LVL_FERR_BIT]                   = ferr_q;
  end

  assign sample_left  = sample_left_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_audio_level_meter.sv
// Scoreboard bench for audio_level_meter: drives I2S frames, predicts samples and
// level words with an arithmetic model, and compares them in a separate monitor.
module tb_audio_level_meter;

  localparam int WIN       = 4;
  localparam int HALF_BITS = 18;
  localparam int BCLK_HALF = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        adc_bclk;
  logic        adc_lrck;
  logic        adc_dat;
  logic        clear_flags;
  logic [15:0] sample_left;
  logic        sample_valid;
  logic [31:0] level_export;

  typedef struct {
    logic [15:0] s;
    logic [31:0] lvl;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   pend = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int peak, lvl_peak, lvl_cnt, wcnt;
  bit clip, ferr;

  always #5 clk = ~clk;

  audio_level_meter #(
    .DATA_WIDTH (16),
    .WINDOW_LOG2(2),
    .DECAY_SHIFT(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .adc_bclk    (adc_bclk),
    .adc_lrck    (adc_lrck),
    .adc_dat     (adc_dat),
    .clear_flags (clear_flags),
    .sample_left (sample_left),
    .sample_valid(sample_valid),
    .level_export(level_export)
  );

  function automatic void model_reset();
    peak = 0; lvl_peak = 0; lvl_cnt = 0; wcnt = 0;
    clip = 1'b0; ferr = 1'b0;
  endfunction

  function automatic void model_sample(input logic [15:0] s);
    int   v, a, d;
    exp_t e;
    v = $signed(s);
    a = (v < 0) ? -v : v;
    if (a > 32767) a = 32767;
    d = peak - (peak / 16);
    peak = (a > d) ? a : d;
    if (v == 32767 || v == -32768) clip = 1'b1;
    wcnt = wcnt + 1;
    if (wcnt == WIN) begin
      wcnt = 0;
      lvl_peak = peak;
      lvl_cnt = (lvl_cnt + 1) % 256;
    end
    e.s = s;
    e.lvl = {ferr, clip, 6'b000000, 8'(lvl_cnt), 16'(lvl_peak)};
    q.push_back(e);
  endfunction

  // monitor: pop on every sample strobe, compare the level word one clk later
  always @(negedge clk) begin
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        checks++;
        if (level_export !== cur.lvl) begin
          errors++;
          $display("FAIL level_export: got %h expected %h (sample %h)", level_export, cur.lvl, cur.s);
        end
        pend = 1'b0;
      end
      if (sample_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sample: sample_valid with sample_left=%h, expected no sample", sample_left);
        end else begin
          cur = q.pop_front();
          if (sample_left !== cur.s) begin
            errors++;
            $display("FAIL sample_left: got %h expected %h", sample_left, cur.s);
          end
          pend = 1'b1;
        end
      end
    end
  end

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic reset_check(input string tag);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val({tag, "_sample_left"}, {16'h0000, sample_left}, 32'h0000_0000);
    check_val({tag, "_sample_valid"}, {31'h0, sample_valid}, 32'h0000_0000);
    check_val({tag, "_level_export"}, level_export, 32'h0000_0000);
    reset = 1'b0;
    model_reset();
    q.delete();
  endtask

  task automatic bit_out(input logic lr, input logic d);
    adc_bclk = 1'b0;
    adc_lrck = lr;
    adc_dat  = d;
    repeat (BCLK_HALF) @(posedge clk);
    #2;
    adc_bclk = 1'b1;
    repeat (BCLK_HALF) @(posedge clk);
    #2;
  endtask

  // bit 0 is the I2S delay slot, bits 1..16 carry the word MSB first
  task automatic half(input logic lr, input logic [15:0] w, input int nbits, input int rst_at);
    logic d;
    for (int i = 0; i < nbits; i++) begin
      d = (i >= 1 && i <= 16) ? w[16 - i] : 1'b0;
      if (i == rst_at) reset_check("mid_shift_reset");
      bit_out(lr, d);
    end
  endtask

  task automatic frame(input logic [15:0] w);
    model_sample(w);
    half(1'b0, w, HALF_BITS, -1);
    half(1'b1, 16'($urandom()), HALF_BITS, -1);
  endtask

  task automatic abort_frame(input logic [15:0] w);
    ferr = 1'b1;
    half(1'b0, w, 10, -1);
    half(1'b1, 16'hFFFF, HALF_BITS, -1);
    check_val("frame_err_set", {31'h0, level_export[31]}, 32'h0000_0001);
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(posedge clk);
    #2;
    clear_flags = 1'b0;
    clip = 1'b0;
    ferr = 1'b0;
    @(negedge clk);
    check_val("flags_cleared", {30'h0, level_export[31:30]}, 32'h0000_0000);
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [15:0] w;
    int          sel;
    reset       = 1'b1;
    adc_bclk    = 1'b0;
    adc_lrck    = 1'b1;
    adc_dat     = 1'b0;
    clear_flags = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    reset_check("reset");
    repeat (20) @(posedge clk);
    #2;

    frame(16'h1234);
    frame(16'h8000);
    check_val("clip_after_8000", {31'h0, level_export[30]}, {31'h0, clip});
    pulse_clear();

    frame(16'h4000);
    for (int i = 0; i < 20; i++) frame(16'h0000);

    abort_frame(16'h5555);
    frame(16'h0F0F);
    pulse_clear();

    half(1'b0, 16'hBEEF, HALF_BITS, 8);
    half(1'b1, 16'h0000, HALF_BITS, -1);
    for (int i = 0; i < 4; i++) frame(16'h0100);
    frame(16'h1234);
    frame(16'hFF00);

    for (int n = 0; n < 36; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       frame(16'h7FFF);
        1:       frame(16'h8000);
        2:       abort_frame(16'($urandom()));
        3:       frame(16'($urandom_range(0, 255)));
        4:       pulse_clear();
        default: begin
          w = 16'($urandom());
          frame(w);
        end
      endcase
    end

    for (int i = 0; i < 2000 && (q.size() != 0 || pend); i++) @(posedge clk);
    check_val("scoreboard_drained", q.size(), 32'd0);
    @(negedge clk);
    check_val("final_flags", {30'h0, level_export[31:30]}, {30'h0, ferr, clip});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
